// File: rtl/pic_control_unit_if.sv
// Bus bundle between the PIC controller and its program memory,
// file register array and ALU.
interface pic_control_unit_if #(
   parameter int PC_W = 8
);
   logic [PC_W-1:0] pc_addr;
   logic [15:0]     instr_data;
   logic [7:0]      rf_addr;
   logic [7:0]      rf_rdata;
   logic [7:0]      rf_wdata;
   logic            rf_we;
   logic [3:0]      alu_inst;
   logic [2:0]      alu_bit;
   logic [7:0]      alu_a;
   logic [7:0]      alu_b;
   logic [7:0]      alu_ans;
   logic            alu_carry;

   modport master (
      output pc_addr, rf_addr, rf_wdata, rf_we,
      output alu_inst, alu_bit, alu_a, alu_b,
      input  instr_data, rf_rdata, alu_ans, alu_carry
   );

   modport slave (
      input  pc_addr, rf_addr, rf_wdata, rf_we,
      input  alu_inst, alu_bit, alu_a, alu_b,
      output instr_data, rf_rdata, alu_ans, alu_carry
   );
endinterface

// File: rtl/pic_control_unit.sv
// Four-phase fetch/decode/execute/writeback controller for an 8-bit
// PIC-style datapath with W register and Z/C status flags.
module pic_control_unit #(
   parameter int PC_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   pic_control_unit_if.master  bus,
   output logic [7:0]          w_reg,
   output logic                z_flag,
   output logic                c_flag,
   output logic                instr_done
);

   typedef enum logic [1:0] {
      S_FETCH     = 2'd0,
      S_DECODE    = 2'd1,
      S_EXECUTE   = 2'd2,
      S_WRITEBACK = 2'd3
   } state_t;

   localparam logic [3:0] OP_NOP = 4'b1000;
   localparam logic [3:0] OP_LIT = 4'b1111;

   state_t          state_reg;
   state_t          state_next;

   logic [PC_W-1:0] pc_reg;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] goto_pc;
   logic [15:0]     ir_reg;
   logic [7:0]      opnd_reg;
   logic [7:0]      res_reg;
   logic            res_carry_reg;

   logic [3:0]      opcode;
   logic            dest_f;
   logic            is_lit;
   logic            is_nop;
   logic            alu_wr;
   logic            rf_write;
   logic            w_write;
   logic            z_upd;
   logic            c_upd;

   // Instruction field decode, always from the captured instruction
   assign opcode   = ir_reg[15:12];
   assign dest_f   = ir_reg[11];
   assign is_lit   = (opcode == OP_LIT);
   assign is_nop   = (opcode == OP_NOP);
   assign alu_wr   = !is_lit && !is_nop;
   assign rf_write = alu_wr && dest_f;
   assign w_write  = alu_wr && !dest_f;

   always_comb begin
      z_upd = 1'b0;
      case (opcode)
         4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
         4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1100: z_upd = 1'b1;
         default:                                     z_upd = 1'b0;
      endcase
   end

   assign c_upd = (opcode == 4'b0010) || (opcode == 4'b0011);

   // GOTO literal is 8 bits; narrow PCs truncate it, wide PCs zero-extend
   generate
      if (PC_W <= 8) begin : g_goto_narrow
         assign goto_pc = ir_reg[PC_W-1:0];
      end else begin : g_goto_wide
         assign goto_pc = {{(PC_W-8){1'b0}}, ir_reg[7:0]};
      end
   endgenerate

   assign pc_next = (is_lit && dest_f) ? goto_pc : pc_reg + PC_W'(1);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH:     state_next = run ? S_DECODE : S_FETCH;
         S_DECODE:    state_next = S_EXECUTE;
         S_EXECUTE:   state_next = S_WRITEBACK;
         S_WRITEBACK: state_next = S_FETCH;
         default:     state_next = S_FETCH;
      endcase
   end

   // Output logic; everything is a function of state so reset clears it at once
   always_comb begin
      bus.pc_addr  = pc_reg;
      bus.rf_addr  = 8'h00;
      bus.rf_wdata = 8'h00;
      bus.rf_we    = 1'b0;
      bus.alu_inst = OP_NOP;
      bus.alu_bit  = 3'd0;
      bus.alu_a    = 8'h00;
      bus.alu_b    = 8'h00;
      instr_done   = 1'b0;
      case (state_reg)
         S_DECODE: begin
            bus.rf_addr = bus.instr_data[7:0];
            bus.alu_bit = bus.instr_data[10:8];
         end
         S_EXECUTE: begin
            bus.rf_addr  = ir_reg[7:0];
            bus.alu_bit  = ir_reg[10:8];
            bus.alu_inst = is_lit ? OP_NOP : opcode;
            bus.alu_a    = w_reg;
            bus.alu_b    = opnd_reg;
         end
         S_WRITEBACK: begin
            bus.rf_addr = ir_reg[7:0];
            bus.alu_bit = ir_reg[10:8];
            instr_done  = 1'b1;
            if (rf_write) begin
               bus.rf_we    = 1'b1;
               bus.rf_wdata = res_reg;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg        <= '0;
         ir_reg        <= 16'h0000;
         opnd_reg      <= 8'h00;
         res_reg       <= 8'h00;
         res_carry_reg <= 1'b0;
         w_reg         <= 8'h00;
         z_flag        <= 1'b0;
         c_flag        <= 1'b0;
      end else begin
         case (state_reg)
            S_DECODE: begin
               ir_reg   <= bus.instr_data;
               opnd_reg <= bus.rf_rdata;
            end
            S_EXECUTE: begin
               res_reg       <= bus.alu_ans;
               res_carry_reg <= bus.alu_carry;
            end
            S_WRITEBACK: begin
               if (w_write) begin
                  w_reg <= res_reg;
               end else if (is_lit && !dest_f) begin
                  w_reg <= ir_reg[7:0];
               end
               if (z_upd) begin
                  z_flag <= (res_reg == 8'h00);
               end
               // SUB reports borrow on alu_carry; C=1 means no borrow
               if (c_upd) begin
                  c_flag <= (opcode == 4'b0011) ? ~res_carry_reg : res_carry_reg;
               end
               pc_reg <= pc_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/pic_control_unit.md
# pic_control_unit

Fetch/decode/execute controller for the 8-bit PIC-style datapath. It fetches 16-bit instructions from a synchronous program memory and reads the file register operand. It drives the ALU's opcode, bit-select and operand inputs, then writes the ALU result back to the W register or the file register and updates the Z/C status flags. Every instruction takes four cycles: FETCH, DECODE, EXECUTE and WRITEBACK.

## Interface
- PC_W, 8, program counter width; the PC wraps at 2^PC_W.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  enables instruction issue; sampled in FETCH only.
- pc_addr  out  PC_W  program memory address.
- instr_data  in  16  program memory data; valid the cycle after pc_addr is presented.
- rf_addr  out  8  file register address (combinational read port).
- rf_rdata  in  8  file register read data, same cycle as rf_addr.
- rf_wdata  out  8  file register write data.
- rf_we  out  1  file register write enable, single-cycle pulse.
- alu_inst  out  4  ALU opcode; 4'b1000 (nop) outside EXECUTE.
- alu_bit  out  3  bit number for bit set/clear.
- alu_a  out  8  ALU operand a, driven from W.
- alu_b  out  8  ALU operand b, driven from the file register.
- alu_ans  in  8  ALU result.
- alu_carry  in  1  ALU carry/borrow, bit 8 of the 9-bit result.
- w_reg  out  8  working register.
- z_flag  out  1  zero flag.
- c_flag  out  1  carry flag.
- instr_done  out  1  one-cycle pulse in WRITEBACK.

## Operation
- Instruction fields:
  - [15:12] opcode
  - [11] d: 0 writes to W, 1 writes to the file register
  - [10:8] bit number
  - [7:0] file address or literal k
- Opcodes 0000–1110 are ALU operations; the opcode passes unchanged to alu_inst. Operands are a = W and b = f.
  - 0000 MOVF
  - 0001 MOVWF
  - 0010 ADD
  - 0011 SUB (f−W)
  - 0100 AND
  - 0101 INC
  - 0110 DEC
  - 0111 XOR
  - 1000 NOP
  - 1001 CLR
  - 1010 IOR
  - 1011 SWAP
  - 1100 COMF
  - 1101 BSF
  - 1110 BCF
- Opcode 1111 is not sent to the ALU:
  - d=0: MOVLW, W ← k.
  - d=1: GOTO, PC ← k[PC_W-1:0].
  - alu_inst stays 4'b1000 for both.
- NOP performs no write and no flag change. PC increments.
- Z update: set to (result == 0) for opcodes 0000, 0010, 0011, 0100, 0101, 0110, 0111, 1001, 1010 and 1100. Z is unchanged for all other opcodes.
- C update, opcodes 0010 and 0011 only:
  - ADD: C = alu_carry.
  - SUB: C = ~alu_carry, so C=1 means no borrow.
- States:
  - FETCH: pc_addr = PC. Stay in FETCH while run=0; go to DECODE when run=1.
  - DECODE:
    - instr_data is valid.
    - rf_addr = instr_data[7:0]; alu_bit = instr_data[10:8].
    - At the end of the cycle, capture the instruction register and rf_rdata into the operand register.
  - EXECUTE:
    - alu_inst = opcode; alu_a = W; alu_b = operand register.
    - At the end of the cycle, capture alu_ans and alu_carry into the result register.
  - WRITEBACK:
    - d=1 on an ALU opcode (except NOP): rf_we=1, rf_addr = file address, rf_wdata = result.
    - d=0 on an ALU opcode (except NOP): W ← result at the end of the cycle.
    - Flags update at the end of the cycle.
    - PC ← PC+1, or ← k for GOTO.
    - instr_done=1.
    - Next state is FETCH.
- alu_bit is stable from DECODE through WRITEBACK. It is therefore valid at least one cycle before alu_inst carries a BSF or BCF opcode.
- MOVWF with d=0 and CLR with d=0 write to W: W ← W and W ← 0 respectively. MOVWF changes no flags; CLR sets Z=1.

## Timing
- Reset values: state FETCH, PC=0, pc_addr=0, W=0, Z=0, C=0, rf_we=0, rf_addr=0, rf_wdata=0, alu_inst=4'b1000, alu_bit=0, alu_a=0, alu_b=0, instr_done=0.
- Reset asserted in any state clears everything immediately and asynchronously.
  - An rf_we pending in WRITEBACK is dropped; no partial write occurs.
  - After release, the first FETCH is at PC 0 on the next edge.
- Latency: exactly 4 cycles per instruction when run=1. pc_addr changes only on the WRITEBACK→FETCH edge.
- rf_we is high for exactly one cycle per file-destination instruction and never in any other state.
- PC wraps from 2^PC_W−1 to 0 with no flag and no stall.
- run deasserting mid-instruction does not stall that instruction; it takes effect at the next FETCH.
- No read-after-write hazard exists: a write in WRITEBACK completes before the next instruction's DECODE read.

## Test plan
- Reset, then MOVLW 0xF03C -> after 4 cycles w_reg=0x3C, pc_addr=1, rf_we never asserted, instr_done pulses once.
- ADDWF 0x2810 with f[0x10]=0xF0, W=0x20 -> single-cycle rf_we in WRITEBACK, rf_addr=0x10, rf_wdata=0x10, C=1, Z=0.
- SUBWF 0x3010 d=0:
  - f=0x05, W=0x05 -> W=0x00, Z=1, C=1.
  - Repeat with f=0x04, W=0x05 -> W=0xFF, Z=0, C=0.
- BSF 0xDF20 with f[0x20]=0x01, prior Z=1, C=1 -> alu_bit=7 from DECODE onward, rf_wdata=0x81, Z and C unchanged.
- GOTO 0xF8FE, then NOP 0x8000 twice -> pc_addr sequence 0xFE, 0xFF, 0x00; no writes.
- run=0 at reset -> pc_addr holds 0 for 10 cycles. Then ADDWF with d=1 and reset asserted in EXECUTE -> rf_we stays 0 and all outputs return to reset values.
